obs_scheduler: RTL
==================

Name: obs_scheduler

Overview:
Owns all obstacle slots for the playfield and sequences them once per frame: scroll left, retire off-screen obstacles, spawn new ones at pseudo-random gaps. Shares the single obs_render instance (and its sprite ROM port) between slots. Each pixel clock it selects the slot whose 16-px window covers the current hpos and drives that slot's x position to the renderer. Sits between game control (frame tick, speed, run/clear) and obs_render.

Parameters:
CONV, 0, low hpos/xpos bits dropped; all x quantities are [9:CONV], width W = 10-CONV
NUM_OBS, 3, number of obstacle slots (1..4)
SPAWN_X, 656, x (sprite right edge) assigned at spawn; must exceed screen width + 16
MIN_GAP, 160, minimum x distance between newest obstacle and SPAWN_X before a spawn

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
i_frame_tick  in  1  one-cycle pulse at start of vblank
i_game_run  in  1  1 = scroll/spawn enabled
i_clear  in  1  one-cycle pulse, invalidate all slots (game restart)
i_speed  in  4  x decrement per frame
i_hpos  in  W  current pixel x
o_xpos  out  W  x of selected obstacle to obs_render
o_obs_valid  out  1  a slot covers the pixel selected this cycle
o_passed  out  1  one-cycle pulse per retired obstacle (score)
o_active_count  out  3  number of valid slots

Behaviour:
- Interface: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset: all slots invalid, x = 0; FSM IDLE; LFSR = 8'hA5; o_xpos = 0, o_obs_valid = 0, o_passed = 0, o_active_count = 0.
- Slot state: valid bit + x[W-1:0]. o_active_count = registered popcount of valid bits.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances one step on every i_frame_tick, regardless of run state.
- FSM IDLE -> SCROLL when i_frame_tick && i_game_run. Otherwise stays IDLE.
- SCROLL: one slot per cycle, index 0..NUM_OBS-1, then -> SPAWN.
  - Valid slot with x <= i_speed: valid cleared; o_passed pulses on that cycle.
  - Other valid slots: x <= x - i_speed.
  - i_speed = 0: no movement, no retire unless x = 0.
- SPAWN: one cycle, then -> IDLE.
  - gap_req = MIN_GAP + 4*lfsr[4:0].
  - Spawn iff a free slot exists and no valid slot has x > SPAWN_X - gap_req.
  - Lowest-index free slot gets valid = 1, x = SPAWN_X. At most one spawn per frame.
- i_frame_tick while FSM not IDLE: ignored (no queuing).
- i_clear: highest priority after reset. All valid bits cleared in that cycle; FSM -> IDLE; LFSR untouched; no o_passed pulses.
- i_speed and i_game_run are sampled on each SCROLL cycle; the value may change mid-sequence.
- Render select, pipelined by 1 cycle, evaluated every cycle:
  - Slot k hits when valid and x-16 <= i_hpos < x, evaluated in W+1 bits (no wrap).
  - Lowest-index hit wins. Registered: o_xpos = winner x, o_obs_valid = 1.
  - No hit: o_xpos = 0, o_obs_valid = 0.
  - The selection reflects slot state of the same cycle. Updates occur only during vblank, so no tearing in the active area.

Test Plan:
- Reset, then i_game_run = 1, i_speed = 4, one i_frame_tick -> exactly 1 spawn in slot 0, x = 656, o_active_count = 1 after SPAWN (tick + NUM_OBS + 2 cycles).
- Continue ticks with speed 4 and LFSR seeded 8'hA5 -> second spawn only once slot0 x <= 656 - (160 + 4*lfsr[4:0]). Check against a reference LFSR model; never more than 3 valid slots.
- Slot at x = 3, speed 4, tick -> slot invalid, o_passed one 1-cycle pulse, count decrements. Slot at x = 4 also retires; x = 5 -> x = 1, stays valid.
- Slots at x = 100 and x = 110, sweep i_hpos 80..120 -> o_xpos = 100 for hpos 84..99, 110 for 100..109, o_obs_valid = 0 elsewhere, each 1 cycle after hpos.
- i_clear asserted mid-SCROLL -> all slots invalid next cycle, FSM IDLE, no o_passed. A second i_frame_tick during SCROLL is ignored (positions move exactly once).
- i_game_run = 0 with ticks -> positions frozen, no spawns, LFSR still advances. rst_n low mid-sequence -> all reset values next edge.

Source files
------------

// File: rtl/obs_scheduler.sv
// obs_scheduler: owns the obstacle slots for the playfield and sequences them
// once per frame (scroll, retire, spawn). Each cycle it also picks the slot
// whose 16-px window covers the current pixel and hands its x to obs_render.
//
// Ports:
//   clk             clock
//   rst_n           synchronous reset, active low
//   i_frame_tick    one-cycle pulse at start of vblank
//   i_game_run      1 = scroll/spawn enabled
//   i_clear         one-cycle pulse, invalidate all slots
//   i_speed         x decrement per frame
//   i_hpos          current pixel x
//   o_xpos          x (right edge) of the selected obstacle
//   o_obs_valid     a slot covers the pixel presented last cycle
//   o_passed        one-cycle pulse per retired obstacle
//   o_active_count  number of valid slots
//
// state  | meaning
// IDLE   | waiting for a frame tick with the game running
// SCROLL | moving/retiring one slot per cycle, index 0..NUM_OBS-1
// SPAWN  | single cycle, places at most one new obstacle at SPAWN_X
module obs_scheduler #(
   parameter int CONV    = 0,
   parameter int NUM_OBS = 3,
   parameter int SPAWN_X = 656,
   parameter int MIN_GAP = 160
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_frame_tick,
   input  logic                 i_game_run,
   input  logic                 i_clear,
   input  logic [3:0]           i_speed,
   input  logic [10-CONV-1:0]   i_hpos,
   output logic [10-CONV-1:0]   o_xpos,
   output logic                 o_obs_valid,
   output logic                 o_passed,
   output logic [2:0]           o_active_count
);

   localparam int W  = 10 - CONV;
   localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
   localparam int HW = 16 >> CONV;
   localparam logic [W-1:0]  SPAWN_XW = W'(SPAWN_X >> CONV);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBS - 1);

   typedef enum logic [1:0] {IDLE, SCROLL, SPAWN} state_t;

   state_t               state;
   logic [NUM_OBS-1:0]   valid;
   logic [W-1:0]         x [NUM_OBS];
   logic [IW-1:0]        idx;
   logic [7:0]           lfsr;

   logic                 lfsr_fb;
   logic [10:0]          gap_req;
   logic [10:0]          thr_full;
   logic [W:0]           thr;
   logic [W-1:0]         spd;
   logic                 spawn_blocked;
   logic                 free_found;
   logic [IW-1:0]        free_idx;
   logic                 sel_hit;
   logic [W-1:0]         sel_x;
   logic [2:0]           valid_cnt;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign gap_req  = 11'(MIN_GAP) + {4'b0, lfsr[4:0], 2'b00};
   assign thr_full = 11'(SPAWN_X) - gap_req;
   assign thr      = thr_full[10:CONV];
   assign spd      = W'(i_speed);

   always_comb begin
      spawn_blocked = 1'b0;
      free_found    = 1'b0;
      free_idx      = '0;
      sel_hit       = 1'b0;
      sel_x         = '0;
      valid_cnt     = '0;
      // descending scan so the lowest index is the last (winning) assignment
      for (int k = NUM_OBS - 1; k >= 0; k--) begin
         if (valid[k] && ({1'b0, x[k]} > thr))
            spawn_blocked = 1'b1;
         if (!valid[k]) begin
            free_found = 1'b0 | 1'b1;
            free_idx   = IW'(k);
         end
         // window x-16 <= hpos < x, one extra bit so x < 16 cannot wrap
         if (valid[k] && (({1'b0, i_hpos} + (W+1)'(HW)) >= {1'b0, x[k]}) &&
             (i_hpos < x[k])) begin
            sel_hit = 1'b1;
            sel_x   = x[k];
         end
         valid_cnt = valid_cnt + 3'(valid[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         valid          <= '0;
         idx            <= '0;
         lfsr           <= 8'hA5;
         o_xpos         <= '0;
         o_obs_valid    <= 1'b0;
         o_passed       <= 1'b0;
         o_active_count <= '0;
         for (int k = 0; k < NUM_OBS; k++)
            x[k] <= '0;
      end else begin
         o_passed       <= 1'b0;
         o_active_count <= valid_cnt;
         o_xpos         <= sel_x;
         o_obs_valid    <= sel_hit;

         if (i_frame_tick)
            lfsr <= {lfsr[6:0], lfsr_fb};

         if (i_clear) begin
            valid <= '0;
            state <= IDLE;
            idx   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (i_frame_tick && i_game_run) begin
                     state <= SCROLL;
                     idx   <= '0;
                  end
               end
               SCROLL: begin
                  if (i_game_run && valid[idx]) begin
                     if (x[idx] <= spd) begin
                        valid[idx] <= 1'b0;
                        o_passed   <= 1'b1;
                     end else begin
                        x[idx] <= x[idx] - spd;
                     end
                  end
                  if (idx == LAST_IDX)
                     state <= SPAWN;
                  else
                     idx <= idx + 1'b1;
               end
               SPAWN: begin
                  if (free_found && !spawn_blocked) begin
                     valid[free_idx] <= 1'b1;
                     x[free_idx]     <= SPAWN_XW;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
